dcache_store_port: RTL

DCACHE_STORE_PORT -- requirements
Module: dcache_store_port

---
 rtl/dcache_pkg.sv | 12 +
 rtl/dcache_line_array.sv | 42 ++++
 rtl/dcache_store_port.sv | 124 ++++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
// dcache_pkg: FSM states, default geometry and address-field layout shared by the store-port cache.
package dcache_pkg;
  localparam int DEF_NUM_LINES = 4;
  localparam int DEF_LINE_WORDS = 4;
  localparam int WORD_OFF = 2;
  localparam int WORD_W = 2;
  localparam int IDX_OFF = 4;
  localparam int IDX_W = 2;
  localparam int TAG_OFF = 6;
  localparam int TAG_W = 26;
  typedef enum logic [1:0] {IDLE, LOOKUP, WRITEBACK, FILL} state_e;
endpackage

// File: rtl/dcache_line_array.sv
// dcache_line_array: valid/dirty/tag/data storage for a direct-mapped cache.
// It has one read/write port, an async read, and an async clear of valid and dirty.
module dcache_line_array
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = DEF_NUM_LINES,
  parameter int LW = DEF_LINE_WORDS * 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] idx_i,
  input  logic             we_i,
  input  logic             wr_valid_i,
  input  logic             wr_dirty_i,
  input  logic [TAG_W-1:0] wr_tag_i,
  input  logic [LW-1:0]    wr_data_i,
  output logic             rd_valid_o,
  output logic             rd_dirty_o,
  output logic [TAG_W-1:0] rd_tag_o,
  output logic [LW-1:0]    rd_data_o
);
  logic [NUM_LINES-1:0] valid_q, dirty_q;
  logic [TAG_W-1:0] tag_q [NUM_LINES];
  logic [LW-1:0] data_q [NUM_LINES];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (we_i) begin
      valid_q[idx_i] <= wr_valid_i;
      dirty_q[idx_i] <= wr_dirty_i;
    end
  always_ff @(posedge clk)
    if (we_i) begin
      tag_q[idx_i] <= wr_tag_i;
      data_q[idx_i] <= wr_data_i;
    end
  assign rd_valid_o = valid_q[idx_i];
  assign rd_dirty_o = dirty_q[idx_i];
  assign rd_tag_o = tag_q[idx_i];
  assign rd_data_o = data_q[idx_i];
endmodule

// File: rtl/dcache_store_port.sv
// dcache_store_port: a direct-mapped write-back cache that commits one drained store at a time.
// Misses evict a dirty victim first, then fill the line and retry the lookup.
module dcache_store_port
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = DEF_NUM_LINES,
  parameter int LINE_WORDS = DEF_LINE_WORDS
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sending_data_to_cache,
  input  logic [63:0]             data_to_cache,
  output logic                    cache_ready_to_catch,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [31:0]             mem_addr,
  output logic [LINE_WORDS*32-1:0] mem_wdata,
  input  logic                    mem_ready,
  input  logic [LINE_WORDS*32-1:0] mem_rdata,
  output logic                    store_done,
  output logic                    busy
);
  localparam int LW = LINE_WORDS * 32;
  state_e state_q, state_d;
  logic [31:2] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic done_q, done_d;
  logic cap, hit, unused_ok;
  logic [TAG_W-1:0] tag, rd_tag, wr_tag;
  logic [IDX_W-1:0] idx;
  logic [WORD_W-1:0] wsel;
  logic rd_valid, rd_dirty, we, wr_valid, wr_dirty;
  logic [LW-1:0] rd_data, wr_data, merged;
  assign unused_ok = ^data_to_cache[33:32];
  assign tag = addr_q[TAG_OFF +: TAG_W];
  assign idx = addr_q[IDX_OFF +: IDX_W];
  assign wsel = addr_q[WORD_OFF +: WORD_W];
  assign cache_ready_to_catch = (state_q == IDLE) && reset;
  assign cap = cache_ready_to_catch && sending_data_to_cache;
  assign addr_d = cap ? data_to_cache[63:34] : addr_q;
  assign wdata_d = cap ? data_to_cache[31:0] : wdata_q;
  assign hit = rd_valid && (rd_tag == tag);
  assign busy = state_q != IDLE;
  assign store_done = done_q;
  always_comb begin
    merged = rd_data;
    merged[wsel*32 +: 32] = wdata_q;
  end
  // Memory outputs depend only on state and held line/packet, so they stay stable until mem_ready.
  always_comb begin
    state_d = state_q;
    done_d = 1'b0;
    we = 1'b0;
    wr_valid = rd_valid;
    wr_dirty = rd_dirty;
    wr_tag = rd_tag;
    wr_data = rd_data;
    mem_req = 1'b0;
    mem_we = 1'b0;
    mem_addr = '0;
    mem_wdata = '0;
    case (state_q)
      IDLE: state_d = cap ? LOOKUP : IDLE;
      LOOKUP:
        if (hit) begin
          we = 1'b1;
          wr_dirty = 1'b1;
          wr_data = merged;
          done_d = 1'b1;
          state_d = IDLE;
        end else state_d = rd_dirty ? WRITEBACK : FILL;
      WRITEBACK: begin
        mem_req = 1'b1;
        mem_we = 1'b1;
        mem_addr = {rd_tag, idx, 4'b0};
        mem_wdata = rd_data;
        if (mem_ready) begin
          we = 1'b1;
          wr_dirty = 1'b0;
          state_d = FILL;
        end
      end
      FILL: begin
        mem_req = 1'b1;
        mem_addr = {tag, idx, 4'b0};
        if (mem_ready) begin
          we = 1'b1;
          wr_valid = 1'b1;
          wr_dirty = 1'b0;
          wr_tag = tag;
          wr_data = mem_rdata;
          state_d = LOOKUP;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      done_q <= done_d;
    end
  dcache_line_array #(.NUM_LINES(NUM_LINES), .LW(LW)) u_arr (
    .clk(clk),
    .rst_n(reset),
    .idx_i(idx),
    .we_i(we),
    .wr_valid_i(wr_valid),
    .wr_dirty_i(wr_dirty),
    .wr_tag_i(wr_tag),
    .wr_data_i(wr_data),
    .rd_valid_o(rd_valid),
    .rd_dirty_o(rd_dirty),
    .rd_tag_o(rd_tag),
    .rd_data_o(rd_data)
  );
endmodule
